regfile_wb: RTL and testbench

Eight-entry, 8-bit register file with a one-stage write-back pipeline. It supplies the ALU's `ReadData1` operand and the register operand feeding the operand mux. It accepts the ALU result as write data. A registered write-back stage holds each result for one cycle before it commits to the array. Read ports forward results from the incoming write and from the pending write-back stage, so back-to-back dependent instructions read correct values with no stall.

---
 rtl/regfile_wb_if.sv | 26 ++
 rtl/regfile_wb.sv | 74 +++++++
 tb/tb_regfile_wb.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Register-file port bundle: two read ports, one write port, write-back debug view.
// Master drives addresses and write requests; slave returns read data and WB status.
interface regfile_wb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              wb_pending;
    logic [ADDR_W-1:0] wb_reg;

    modport master (
        output ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData,
        input  ReadData1, ReadData2, wb_pending, wb_reg
    );

    modport slave (
        input  ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData,
        output ReadData1, ReadData2, wb_pending, wb_reg
    );
endinterface

// File: rtl/regfile_wb.sv
// 8x8 register file with a one-stage write-back register in front of the array.
// Latency: reads combinational with forwarding; a write commits to the array two edges later.
// Backpressure: none, accepts one write every cycle.
module regfile_wb #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_wb_if.slave rf
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wb_v_q,    wb_v_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [DATA_W-1:0] rd1_dat,   rd2_dat;

    // Capture the incoming write and retire the previous one on the same edge.
    always_comb begin
        wb_v_d    = rf.RegWrite && (rf.WriteReg != '0);
        wb_addr_d = rf.WriteReg;
        wb_data_d = rf.WriteData;
        regs_d    = regs_q;
        if (wb_v_q) begin
            regs_d[wb_addr_q] = wb_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_v_q    <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            regs_q    <= regs_d;
            wb_v_q    <= wb_v_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Newest source wins: incoming write, then write-back stage, then array.
    always_comb begin
        rd1_dat = regs_q[rf.ReadReg1];
        if (rf.ReadReg1 == '0) begin
            rd1_dat = '0;
        end else if (rf.RegWrite && (rf.WriteReg == rf.ReadReg1)) begin
            rd1_dat = rf.WriteData;
        end else if (wb_v_q && (wb_addr_q == rf.ReadReg1)) begin
            rd1_dat = wb_data_q;
        end

        rd2_dat = regs_q[rf.ReadReg2];
        if (rf.ReadReg2 == '0) begin
            rd2_dat = '0;
        end else if (rf.RegWrite && (rf.WriteReg == rf.ReadReg2)) begin
            rd2_dat = rf.WriteData;
        end else if (wb_v_q && (wb_addr_q == rf.ReadReg2)) begin
            rd2_dat = wb_data_q;
        end
    end

    assign rf.ReadData1  = rd1_dat;
    assign rf.ReadData2  = rd2_dat;
    assign rf.wb_pending = wb_v_q;
    assign rf.wb_reg     = wb_addr_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Random and directed traffic against an architectural-value model of the register file.
module tb_regfile_wb;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   cmp_en;

    regfile_wb_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile_wb #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each register's latest written value is visible immediately.
    logic [7:0] arch [8];
    bit         m_pend;
    logic [2:0] m_wbreg;

    initial begin
        for (int i = 0; i < 8; i++) arch[i] = 8'h00;
        m_pend  = 1'b0;
        m_wbreg = 3'd0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) arch[i] = 8'h00;
            m_pend  = 1'b0;
            m_wbreg = 3'd0;
        end else begin
            if (bus.RegWrite && bus.WriteReg != 3'd0) arch[bus.WriteReg] = bus.WriteData;
            m_pend  = bus.RegWrite && (bus.WriteReg != 3'd0);
            m_wbreg = bus.WriteReg;
        end
    end

    function automatic logic [7:0] model_read(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (bus.RegWrite && bus.WriteReg == a) return bus.WriteData;
        return arch[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rd1_model", bus.ReadData1, model_read(bus.ReadReg1));
            chk("rd2_model", bus.ReadData2, model_read(bus.ReadReg2));
            chk("wb_pending_model", bus.wb_pending, m_pend);
            chk("wb_reg_model", bus.wb_reg, m_wbreg);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2);
        bus.RegWrite  = we;
        bus.WriteReg  = wa;
        bus.WriteData = wd;
        bus.ReadReg1  = r1;
        bus.ReadReg2  = r2;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = 3'd0;
        bus.WriteData = 8'h00;
        bus.ReadReg1  = 3'd0;
        bus.ReadReg2  = 3'd0;
        cyc();
        cyc();
        cmp_en = 1'b1;
        chk("reset_pending", bus.wb_pending, 1'b0);
        chk("reset_wb_reg", bus.wb_reg, 3'd0);
        rst_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            cyc();
            drive(1'b0, 3'd0, 8'h00, a[2:0], a[2:0]);
            chk("reset_read1", bus.ReadData1, 8'h00);
            chk("reset_read2", bus.ReadData2, 8'h00);
        end

        // Single write visible via each source in turn.
        cyc(); drive(1'b1, 3'd3, 8'hA5, 3'd3, 3'd0);
        chk("basic_c0", bus.ReadData1, 8'hA5);
        chk("basic_c0_pend", bus.wb_pending, 1'b0);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd0);
        chk("basic_c1", bus.ReadData1, 8'hA5);
        chk("basic_c1_pend", bus.wb_pending, 1'b1);
        chk("basic_c1_wbreg", bus.wb_reg, 3'd3);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd0);
        chk("basic_c2", bus.ReadData1, 8'hA5);
        chk("basic_c2_pend", bus.wb_pending, 1'b0);

        cyc(); drive(1'b1, 3'd5, 8'h11, 3'd0, 3'd5);
        chk("b2b_c0", bus.ReadData2, 8'h11);
        cyc(); drive(1'b1, 3'd5, 8'h22, 3'd0, 3'd5);
        chk("b2b_c1", bus.ReadData2, 8'h22);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd5);
        chk("b2b_c2", bus.ReadData2, 8'h22);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd5);
        chk("b2b_c3", bus.ReadData2, 8'h22);

        cyc(); drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
        chk("r0_c0_rd1", bus.ReadData1, 8'h00);
        chk("r0_c0_rd2", bus.ReadData2, 8'h00);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        chk("r0_c1_pend", bus.wb_pending, 1'b0);
        chk("r0_c1_rd1", bus.ReadData1, 8'h00);

        cyc(); drive(1'b1, 3'd2, 8'h40, 3'd2, 3'd2);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
        chk("prio_setup", bus.ReadData1, 8'h40);
        cyc(); drive(1'b1, 3'd2, 8'h41, 3'd2, 3'd2);
        chk("prio_c0_rd1", bus.ReadData1, 8'h41);
        cyc(); drive(1'b1, 3'd2, 8'h42, 3'd2, 3'd2);
        chk("prio_c1_rd1", bus.ReadData1, 8'h42);
        chk("prio_c1_rd2", bus.ReadData2, 8'h42);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
        chk("prio_c2_rd2", bus.ReadData2, 8'h42);

        // Reset while a write sits in the write-back stage.
        cyc(); drive(1'b1, 3'd6, 8'h5C, 3'd6, 3'd2);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd2);
        chk("midrst_pend_before", bus.wb_pending, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_pend_after", bus.wb_pending, 1'b0);
        chk("midrst_rd_r6", bus.ReadData1, 8'h00);
        chk("midrst_rd_r2", bus.ReadData2, 8'h00);
        cyc();
        rst_n = 1'b1;
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd2);
        chk("midrst_no_commit", bus.ReadData1, 8'h00);

        cyc(); drive(1'b1, 3'd7, 8'h01 << 3, 3'd7, 3'd7);
        chk("shift_c0", bus.ReadData1, 8'h08);
        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd7, 3'd1);
        chk("shift_c1", bus.ReadData1, 8'h08);

        for (int n = 0; n < 1000; n++) begin
            cyc();
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        cyc(); drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        cyc();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
